// File: rtl/rv32_decode_pkg.sv
// Shared types and constants for the RV32I (+Zicsr/fence) decode queue:
// decoded record layout, opcode map and one-hot instruction class encoding.
package rv32_decode_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [63:0] cls;
  } dec_t;

  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_I_A    = 7'b0010011,
    OPC_I_L    = 7'b0000011,
    OPC_S      = 7'b0100011,
    OPC_B      = 7'b1100011,
    OPC_J      = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_SYSTEM = 7'b1110011,
    OPC_FENCE  = 7'b0001111
  } opcode_e;

  localparam logic [63:0] inst_add     = 64'd1 << 0;
  localparam logic [63:0] inst_sub     = 64'd1 << 1;
  localparam logic [63:0] inst_sll     = 64'd1 << 2;
  localparam logic [63:0] inst_slt     = 64'd1 << 3;
  localparam logic [63:0] inst_sltu    = 64'd1 << 4;
  localparam logic [63:0] inst_xor     = 64'd1 << 5;
  localparam logic [63:0] inst_srl     = 64'd1 << 6;
  localparam logic [63:0] inst_sra     = 64'd1 << 7;
  localparam logic [63:0] inst_or      = 64'd1 << 8;
  localparam logic [63:0] inst_and     = 64'd1 << 9;
  localparam logic [63:0] inst_addi    = 64'd1 << 10;
  localparam logic [63:0] inst_slti    = 64'd1 << 11;
  localparam logic [63:0] inst_sltiu   = 64'd1 << 12;
  localparam logic [63:0] inst_xori    = 64'd1 << 13;
  localparam logic [63:0] inst_ori     = 64'd1 << 14;
  localparam logic [63:0] inst_andi    = 64'd1 << 15;
  localparam logic [63:0] inst_slli    = 64'd1 << 16;
  localparam logic [63:0] inst_srli    = 64'd1 << 17;
  localparam logic [63:0] inst_srai    = 64'd1 << 18;
  localparam logic [63:0] inst_lb      = 64'd1 << 19;
  localparam logic [63:0] inst_lh      = 64'd1 << 20;
  localparam logic [63:0] inst_lw      = 64'd1 << 21;
  localparam logic [63:0] inst_lbu     = 64'd1 << 22;
  localparam logic [63:0] inst_lhu     = 64'd1 << 23;
  localparam logic [63:0] inst_sb      = 64'd1 << 24;
  localparam logic [63:0] inst_sh      = 64'd1 << 25;
  localparam logic [63:0] inst_sw      = 64'd1 << 26;
  localparam logic [63:0] inst_beq     = 64'd1 << 27;
  localparam logic [63:0] inst_bne     = 64'd1 << 28;
  localparam logic [63:0] inst_blt     = 64'd1 << 29;
  localparam logic [63:0] inst_bge     = 64'd1 << 30;
  localparam logic [63:0] inst_bltu    = 64'd1 << 31;
  localparam logic [63:0] inst_bgeu    = 64'd1 << 32;
  localparam logic [63:0] inst_jal     = 64'd1 << 33;
  localparam logic [63:0] inst_jalr    = 64'd1 << 34;
  localparam logic [63:0] inst_lui     = 64'd1 << 35;
  localparam logic [63:0] inst_auipc   = 64'd1 << 36;
  localparam logic [63:0] inst_fence   = 64'd1 << 37;
  localparam logic [63:0] inst_fence_i = 64'd1 << 38;
  localparam logic [63:0] inst_ecall   = 64'd1 << 39;
  localparam logic [63:0] inst_ebreak  = 64'd1 << 40;
  localparam logic [63:0] inst_csrrw   = 64'd1 << 41;
  localparam logic [63:0] inst_csrrs   = 64'd1 << 42;
  localparam logic [63:0] inst_csrrc   = 64'd1 << 43;
  localparam logic [63:0] inst_csrrwi  = 64'd1 << 44;
  localparam logic [63:0] inst_csrrsi  = 64'd1 << 45;
  localparam logic [63:0] inst_csrrci  = 64'd1 << 46;

  localparam logic [31:0] NOOP = 32'h00000013;

  // Decode of NOOP (ADDI x0,x0,0), substituted for illegal entries.
  localparam dec_t NOOP_DEC = '{rd: '0, rs1: '0, rs2: '0, imm: '0, cls: inst_addi};

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I (+Zicsr/fence) field and class decoder.
module rv32_decode_comb
  import rv32_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  opcode_e    w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_op = opcode_e'(i_instr[6:0]);
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  always_comb begin
    o_dec.rd  = i_instr[11:7];
    o_dec.rs1 = i_instr[19:15];
    o_dec.rs2 = i_instr[24:20];
    o_dec.imm = '0;
    o_dec.cls = '0;
    case (w_op)
      OPC_R: begin
        case ({w_f7, w_f3})
          {7'h00, 3'b000}: o_dec.cls = inst_add;
          {7'h20, 3'b000}: o_dec.cls = inst_sub;
          {7'h00, 3'b001}: o_dec.cls = inst_sll;
          {7'h00, 3'b010}: o_dec.cls = inst_slt;
          {7'h00, 3'b011}: o_dec.cls = inst_sltu;
          {7'h00, 3'b100}: o_dec.cls = inst_xor;
          {7'h00, 3'b101}: o_dec.cls = inst_srl;
          {7'h20, 3'b101}: o_dec.cls = inst_sra;
          {7'h00, 3'b110}: o_dec.cls = inst_or;
          {7'h00, 3'b111}: o_dec.cls = inst_and;
          default:         o_dec.cls = '0;
        endcase
      end
      OPC_I_A: begin
        o_dec.rs2 = '0;
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
        case (w_f3)
          3'b000:  o_dec.cls = inst_addi;
          3'b010:  o_dec.cls = inst_slti;
          3'b011:  o_dec.cls = inst_sltiu;
          3'b100:  o_dec.cls = inst_xori;
          3'b110:  o_dec.cls = inst_ori;
          3'b111:  o_dec.cls = inst_andi;
          3'b001:  o_dec.cls = (w_f7 == 7'h00) ? inst_slli : '0;
          default: o_dec.cls = (w_f7 == 7'h00) ? inst_srli :
                               (w_f7 == 7'h20) ? inst_srai : '0;
        endcase
      end
      OPC_I_L: begin
        o_dec.rs2 = '0;
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
        case (w_f3)
          3'b000:  o_dec.cls = inst_lb;
          3'b001:  o_dec.cls = inst_lh;
          3'b010:  o_dec.cls = inst_lw;
          3'b100:  o_dec.cls = inst_lbu;
          3'b101:  o_dec.cls = inst_lhu;
          default: o_dec.cls = '0;
        endcase
      end
      OPC_JALR: begin
        o_dec.rs2 = '0;
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
        o_dec.cls = (w_f3 == 3'b000) ? inst_jalr : '0;
      end
      OPC_S: begin
        o_dec.rd  = '0;
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        case (w_f3)
          3'b000:  o_dec.cls = inst_sb;
          3'b001:  o_dec.cls = inst_sh;
          3'b010:  o_dec.cls = inst_sw;
          default: o_dec.cls = '0;
        endcase
      end
      OPC_B: begin
        o_dec.rd  = '0;
        o_dec.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                     i_instr[30:25], i_instr[11:8], 1'b0};
        case (w_f3)
          3'b000:  o_dec.cls = inst_beq;
          3'b001:  o_dec.cls = inst_bne;
          3'b100:  o_dec.cls = inst_blt;
          3'b101:  o_dec.cls = inst_bge;
          3'b110:  o_dec.cls = inst_bltu;
          3'b111:  o_dec.cls = inst_bgeu;
          default: o_dec.cls = '0;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        o_dec.rs1 = '0;
        o_dec.rs2 = '0;
        o_dec.imm = {i_instr[31:12], 12'b0};
        o_dec.cls = (w_op == OPC_LUI) ? inst_lui : inst_auipc;
      end
      OPC_J: begin
        o_dec.rs1 = '0;
        o_dec.rs2 = '0;
        o_dec.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                     i_instr[20], i_instr[30:21], 1'b0};
        o_dec.cls = inst_jal;
      end
      OPC_SYSTEM: begin
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
        case (w_f3)
          3'b000:  o_dec.cls = i_instr[20] ? inst_ebreak : inst_ecall;
          3'b001:  o_dec.cls = inst_csrrw;
          3'b010:  o_dec.cls = inst_csrrs;
          3'b011:  o_dec.cls = inst_csrrc;
          3'b101:  o_dec.cls = inst_csrrwi;
          3'b110:  o_dec.cls = inst_csrrsi;
          3'b111:  o_dec.cls = inst_csrrci;
          default: o_dec.cls = '0;
        endcase
      end
      OPC_FENCE: begin
        case (w_f3)
          3'b000:  o_dec.cls = inst_fence;
          3'b001:  o_dec.cls = inst_fence_i;
          default: o_dec.cls = '0;
        endcase
      end
      default: o_dec.cls = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_queue.sv
// Handshaked decode stage: decodes on enqueue into a DEPTH-entry FIFO.
// Optional DEC_PERF_CNT_EN adds saturating push / illegal-push counters.
module rv32_decode_queue
  import rv32_decode_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PC_W           = 32,
  parameter bit          NOP_ON_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [$bits(dec_t)-1:0]    out_dec,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DEC_PERF_CNT_EN
  ,
  output logic [31:0]                perf_decoded,
  output logic [31:0]                perf_illegal
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dec_t             r_dec_mem [DEPTH];
  logic [PC_W-1:0]  r_pc_mem  [DEPTH];
  logic [DEPTH-1:0] r_ill_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  dec_t w_dec_raw;
  dec_t w_dec_wr;
  logic w_ill;
  logic w_push;
  logic w_pop;
  logic w_out_valid;

  rv32_decode_comb u_dec (
    .i_instr (in_instr),
    .o_dec   (w_dec_raw)
  );

  assign w_ill       = (w_dec_raw.cls == '0);
  assign w_dec_wr    = (NOP_ON_ILLEGAL && w_ill) ? NOOP_DEC : w_dec_raw;
  assign w_out_valid = (r_count != '0);
  assign in_ready    = !flush && ((r_count < CW'(DEPTH)) || out_ready);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // Storage is not reset: every output is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_dec_mem[r_wr_ptr] <= w_dec_wr;
      r_pc_mem[r_wr_ptr]  <= in_pc;
      r_ill_mem[r_wr_ptr] <= w_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid   = w_out_valid;
  assign out_pc      = w_out_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign out_dec     = w_out_valid ? r_dec_mem[r_rd_ptr] : '0;
  assign out_illegal = w_out_valid && r_ill_mem[r_rd_ptr];
  assign count       = r_count;

`ifdef DEC_PERF_CNT_EN
  logic [31:0] r_perf_decoded;
  logic [31:0] r_perf_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_decoded <= '0;
      r_perf_illegal <= '0;
    end else if (w_push) begin
      if (r_perf_decoded != '1)         r_perf_decoded <= r_perf_decoded + 32'd1;
      if (w_ill && r_perf_illegal != '1) r_perf_illegal <= r_perf_illegal + 32'd1;
    end
  end

  assign perf_decoded = r_perf_decoded;
  assign perf_illegal = r_perf_illegal;
`endif

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Bench for rv32_decode_queue: vector table through a scoreboard plus
// hand sequences for backpressure, flush and mid-stream reset.
module tb_rv32_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned DW    = 111;
  localparam int          NV    = 18;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [DW-1:0]   out_dec;
  logic            out_illegal;
  logic [2:0]      count;
`ifdef DEC_PERF_CNT_EN
  logic [31:0]     perf_decoded;
  logic [31:0]     perf_illegal;
  logic [31:0]     p_snap;
`endif

  rv32_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_ON_ILLEGAL(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_dec     (out_dec),
    .out_illegal (out_illegal),
    .count       (count)
`ifdef DEC_PERF_CNT_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_illegal (perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [63:0] cls;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    vec_t            v;
  } sb_t;

  vec_t          vec [NV];
  vec_t          cur_exp;
  sb_t           sb [$];
  sb_t           mon_e;
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            rnd_ready = 1'b0;
  logic [DW-1:0] hold_dec;

  // Output record layout: {rd, rs1, rs2, imm, class}
  function automatic logic [4:0]  f_rd (input logic [DW-1:0] d); return d[110:106]; endfunction
  function automatic logic [4:0]  f_rs1(input logic [DW-1:0] d); return d[105:101]; endfunction
  function automatic logic [4:0]  f_rs2(input logic [DW-1:0] d); return d[100:96];  endfunction
  function automatic logic [31:0] f_imm(input logic [DW-1:0] d); return d[95:64];   endfunction
  function automatic logic [63:0] f_cls(input logic [DW-1:0] d); return d[63:0];    endfunction

  // cbit < 0 marks an illegal encoding, expected as the ADDI x0,x0,0 record.
  function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input int cbit);
    vec_t v;
    v.instr = instr;
    if (cbit < 0) begin
      v.rd = 5'd0; v.rs1 = 5'd0; v.rs2 = 5'd0; v.imm = 32'd0;
      v.cls = 64'd1 << 10;
      v.ill = 1'b1;
    end else begin
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
      v.cls = 64'd1 << cbit;
      v.ill = 1'b0;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input int idx, input logic [PC_W-1:0] pc);
    int unsigned waited = 0;
    logic        acc    = 1'b0;
    in_valid = 1'b1;
    in_instr = vec[idx].instr;
    in_pc    = pc;
    cur_exp  = vec[idx];
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      waited++;
    end while (!acc && waited < 50);
    chk($sformatf("push_accept[%0d]", idx), acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", count, 0);
    out_ready = 1'b0;
  endtask

  // Scoreboard: record accepted inputs, compare each consumed head entry.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("pc[%08h]", mon_e.v.instr),  out_pc,           mon_e.pc);
          chk($sformatf("rd[%08h]", mon_e.v.instr),  f_rd(out_dec),    mon_e.v.rd);
          chk($sformatf("rs1[%08h]", mon_e.v.instr), f_rs1(out_dec),   mon_e.v.rs1);
          chk($sformatf("rs2[%08h]", mon_e.v.instr), f_rs2(out_dec),   mon_e.v.rs2);
          chk($sformatf("imm[%08h]", mon_e.v.instr), f_imm(out_dec),   mon_e.v.imm);
          chk($sformatf("cls[%08h]", mon_e.v.instr), f_cls(out_dec),   mon_e.v.cls);
          chk($sformatf("ill[%08h]", mon_e.v.instr), out_illegal,      mon_e.v.ill);
        end
      end
      if (in_valid && in_ready) begin
        mon_e.pc = in_pc;
        mon_e.v  = cur_exp;
        sb.push_back(mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    cur_exp = mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, -1);

    vec[0]  = mk(32'h002081B3, 5'd3, 5'd1, 5'd2,  32'h0,        0);  // ADD x3,x1,x2
    vec[1]  = mk(32'h00512423, 5'd0, 5'd2, 5'd5,  32'h8,        26); // SW x5,8(x2)
    vec[2]  = mk(32'h407302B3, 5'd5, 5'd6, 5'd7,  32'h0,        1);  // SUB
    vec[3]  = mk(32'hFFF10093, 5'd1, 5'd2, 5'd0,  32'hFFFFFFFF, 10); // ADDI x1,x2,-1
    vec[4]  = mk(32'hFFC1A203, 5'd4, 5'd3, 5'd0,  32'hFFFFFFFC, 21); // LW x4,-4(x3)
    vec[5]  = mk(32'hFE208CE3, 5'd0, 5'd1, 5'd2,  32'hFFFFFFF8, 27); // BEQ -8
    vec[6]  = mk(32'h123453B7, 5'd7, 5'd0, 5'd0,  32'h12345000, 35); // LUI
    vec[7]  = mk(32'h001000EF, 5'd1, 5'd0, 5'd0,  32'h00000800, 33); // JAL +2048
    vec[8]  = mk(32'h00008067, 5'd0, 5'd1, 5'd0,  32'h0,        34); // JALR
    vec[9]  = mk(32'h00009067, 5'd0, 5'd0, 5'd0,  32'h0,        -1); // JALR funct3!=0
    vec[10] = mk(32'h00100073, 5'd0, 5'd0, 5'd1,  32'h1,        40); // EBREAK
    vec[11] = mk(32'h00000073, 5'd0, 5'd0, 5'd0,  32'h0,        39); // ECALL
    vec[12] = mk(32'h3001F2F3, 5'd5, 5'd3, 5'd0,  32'h300,      46); // CSRRCI
    vec[13] = mk(32'h40315093, 5'd1, 5'd2, 5'd0,  32'h403,      18); // SRAI
    vec[14] = mk(32'h40311093, 5'd0, 5'd0, 5'd0,  32'h0,        -1); // SLLI bad funct7
    vec[15] = mk(32'hFFFFFFFF, 5'd0, 5'd0, 5'd0,  32'h0,        -1); // unknown opcode
    vec[16] = mk(32'h0FF0000F, 5'd0, 5'd0, 5'd31, 32'h0,        37); // FENCE
    vec[17] = mk(32'hFFFFF117, 5'd2, 5'd0, 5'd0,  32'hFFFFF000, 36); // AUIPC

    repeat (2) tick();
    chk("rst_out_valid",   out_valid,   1'b0);
    chk("rst_count",       count,       0);
    chk("rst_out_pc",      out_pc,      0);
    chk("rst_out_dec",     out_dec,     0);
    chk("rst_out_illegal", out_illegal, 1'b0);
`ifdef DEC_PERF_CNT_EN
    chk("rst_perf_decoded", perf_decoded, 0);
    chk("rst_perf_illegal", perf_illegal, 0);
`endif
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);

    // Single push into empty queue: visible right after the accepting edge.
    push(0, 32'h100);
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_count",     count,     1);
    chk("lat_rd",        f_rd(out_dec),  5'd3);
    chk("lat_rs1",       f_rs1(out_dec), 5'd1);
    chk("lat_rs2",       f_rs2(out_dec), 5'd2);
    chk("lat_imm",       f_imm(out_dec), 32'h0);
    chk("lat_cls",       f_cls(out_dec), 64'h1);
    chk("lat_illegal",   out_illegal,    1'b0);
    hold_dec = out_dec;
    tick();
    chk("hold_out_dec",   out_dec,   hold_dec);
    chk("hold_out_valid", out_valid, 1'b1);
    drain();

    // Full table with random consumer stalls.
    rnd_ready = 1'b1;
    for (int i = 0; i < NV; i++) push(i, 32'h1000 + 32'(4 * i));
    rnd_ready = 1'b0;
    drain();

    // Backpressure: fill, hold 5th, then simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(i, 32'h2000 + 32'(4 * i));
    chk("full_count",    count,    4);
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_instr = vec[4].instr; in_pc = 32'h2010; cur_exp = vec[4];
    tick();
    tick();
    chk("held_count",    count,    4);
    chk("held_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("fullpop_in_ready", in_ready, 1'b1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_count", count, 4);
    drain();

    // Illegal word.
`ifdef DEC_PERF_CNT_EN
    p_snap = perf_illegal;
`endif
    push(15, 32'h3000);
    chk("ill_out_illegal", out_illegal,    1'b1);
    chk("ill_cls",         f_cls(out_dec), 64'd1 << 10);
    chk("ill_rd",          f_rd(out_dec),  5'd0);
    chk("ill_rs1",         f_rs1(out_dec), 5'd0);
    chk("ill_imm",         f_imm(out_dec), 32'h0);
`ifdef DEC_PERF_CNT_EN
    chk("ill_perf_illegal", perf_illegal, p_snap + 32'd1);
`endif
    drain();

    // Flush with a same-cycle input.
    for (int i = 0; i < 3; i++) push(5 + i, 32'h4000 + 32'(4 * i));
    chk("pre_flush_count", count, 3);
`ifdef DEC_PERF_CNT_EN
    p_snap = perf_decoded;
`endif
    flush = 1'b1; in_valid = 1'b1; in_instr = vec[8].instr; in_pc = 32'h4100; cur_exp = vec[8];
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count",     count,     0);
    chk("flush_out_valid", out_valid, 1'b0);
`ifdef DEC_PERF_CNT_EN
    chk("flush_perf_decoded", perf_decoded, p_snap);
`endif
    tick();
    chk("post_flush_count", count,     0);
    chk("post_flush_valid", out_valid, 1'b0);

    // Reset mid-stream with push and pop both active.
    push(9, 32'h5000);
    push(10, 32'h5004);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = vec[11].instr; in_pc = 32'h5008; cur_exp = vec[11];
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mrst_out_valid",   out_valid,   1'b0);
    chk("mrst_count",       count,       0);
    chk("mrst_out_pc",      out_pc,      0);
    chk("mrst_out_dec",     out_dec,     0);
    chk("mrst_out_illegal", out_illegal, 1'b0);
`ifdef DEC_PERF_CNT_EN
    chk("mrst_perf_decoded", perf_decoded, 0);
`endif
    rst_n = 1'b1;
    push(1, 32'h6000);
    chk("post_rst_out_valid", out_valid, 1'b1);
    chk("post_rst_count",     count,     1);
    chk("post_rst_pc",        out_pc,    32'h6000);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
